aquarium_mode_seq: RTL and testbench
====================================

AQUARIUM_MODE_SEQ -- requirements
Module: aquarium_mode_seq

Interface
REQ-001 The block SHALL have parameter MIN_DWELL, default 16: minimum number of cycles a newly selected mode is held, legal range 1-255.
REQ-002 The block SHALL have parameter BAD_LIMIT, default 3: number of consecutive invalid requests that forces error mode, legal range 1-15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a mode request is present.
REQ-006 The block SHALL have port req_mode, input, 3 bits: requested mode index; 0-5 are valid, 6-7 are invalid.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port fault, input, 1 bit: level-sensitive sensor fault.
REQ-009 The block SHALL have port fault_clr, input, 1 bit: operator clear of the error state.
REQ-010 The block SHALL have port select, output, 5 bits: registered mode code driving the downstream 7-input output mux.
REQ-011 The block SHALL have port mode_changed, output, 1 bit: one-cycle pulse in the cycle select takes a new value.
REQ-012 The block SHALL have port err, output, 1 bit: high while in error mode.

Function
REQ-013 select SHALL encode modes as follows:
- 0 -> 00000
- 1 -> 00001
- 2 -> 00010
- 3 -> 00100
- 4 -> 01000
- 5 -> 10000
- error -> 11111
- No other value SHALL ever appear on select.
REQ-014 The FSM SHALL have states READY, DWELL and ERROR; req_ready SHALL be 1 only in READY, combinationally from state.
REQ-015 A handshake SHALL occur in any cycle where req_valid=1 and req_ready=1; outside a handshake, req_mode SHALL be ignored.
REQ-016 Valid handshake, req_mode differs from the current mode:
- next edge: select = new code, mode_changed=1 for one cycle
- 8-bit dwell counter loaded with MIN_DWELL-1
- state -> DWELL
- bad counter cleared to 0
REQ-017 Valid handshake, req_mode equals the current mode: select unchanged, no mode_changed pulse, state stays READY, bad counter cleared.
REQ-018 Handshake with req_mode 6 or 7: select unchanged, state stays READY, 4-bit bad counter increments by 1.
REQ-019 When an invalid handshake brings the bad counter to BAD_LIMIT, the next edge SHALL enter ERROR instead.
REQ-020 In DWELL the counter SHALL decrement each cycle; in the cycle it reads 0 the next state SHALL be READY.
REQ-021 Handshake-to-next-handshake spacing SHALL therefore be exactly MIN_DWELL+1 cycles minimum; with MIN_DWELL=1, DWELL lasts one cycle.
REQ-022 fault=1 in READY or DWELL SHALL cause, at the next edge:
- state ERROR, select=11111, err=1, mode_changed=1
- dwell counter cleared
REQ-023 fault SHALL take priority over a simultaneous handshake; the request is not consumed.
REQ-024 ERROR SHALL be exited only when fault_clr=1 and fault=0 in the same cycle. The next edge then sets:
- state READY, select=00000, err=0, mode_changed=1
- bad counter cleared
REQ-025 fault_clr while fault=1 SHALL have no effect; fault_clr outside ERROR SHALL be ignored.
REQ-026 Entry into ERROR via the bad counter SHALL produce the same outputs as entry via fault.
REQ-027 In ERROR, fault held high SHALL keep the block in ERROR with no further mode_changed pulses.

Reset
REQ-028 With rst=1 at a rising edge, the next state SHALL be:
- state READY, select=00000, mode_changed=0, err=0
- dwell counter 0, bad counter 0
REQ-029 rst SHALL override every other input in every state, including mid-DWELL and in ERROR.
REQ-030 req_ready SHALL read 1 in the first cycle after reset is released.

Verification
REQ-031 Mode change: reset, then req_valid=1, req_mode=3 for one cycle -> next cycle select=00100 and mode_changed=1; req_ready=0 for 16 cycles, then 1.
REQ-032 Dwell blocking: hold req_valid=1, req_mode=5 continuously after the first request -> select=10000 exactly 17 cycles after the first handshake.
REQ-033 Invalid burst: three handshakes with req_mode=7, BAD_LIMIT=3 -> select=11111 and err=1 after the third; a req_mode=2 between bad requests resets the count.
REQ-034 Fault priority: fault=1 in the same cycle as req_mode=4, req_valid=1 -> select=11111, not 01000.
REQ-035 Clear: fault_clr=1 with fault=1 -> stays 11111; then fault=0, fault_clr=1 -> select=00000, err=0, mode_changed pulse.
REQ-036 Reset mid-DWELL: rst=1 at dwell count 7 -> select=00000 and req_ready=1 in the cycle after rst falls.

Source files
------------

// File: rtl/aquarium_mode_seq.sv
// Aquarium mode sequencer: accepts mode requests, enforces a minimum dwell per
// new mode, and latches an error mode on sensor fault or repeated bad requests.
module aquarium_mode_seq #(
  parameter int MIN_DWELL = 16,
  parameter int BAD_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  input  logic       fault,
  input  logic       fault_clr,
  output logic [4:0] select,
  output logic       mode_changed,
  output logic       err
);

  // state    | meaning
  // ST_READY | idle, accepting mode requests
  // ST_DWELL | holding a newly selected mode for MIN_DWELL cycles
  // ST_ERROR | error code on select until fault_clr with fault low
  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_DWELL = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(MIN_DWELL - 1);
  localparam logic [3:0] BAD_LIM    = 4'(BAD_LIMIT);
  localparam logic [4:0] SEL_ERROR  = 5'b11111;

  state_t     state_q, state_d;
  logic [4:0] select_q, select_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] bad_q, bad_d;
  logic       mc_q, mc_d;
  logic [3:0] bad_inc;
  logic [4:0] req_code;

  function automatic logic [4:0] encode_mode(input logic [2:0] m);
    logic [4:0] code;
    case (m)
      3'd1:    code = 5'b00001;
      3'd2:    code = 5'b00010;
      3'd3:    code = 5'b00100;
      3'd4:    code = 5'b01000;
      3'd5:    code = 5'b10000;
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  assign req_code = encode_mode(req_mode);
  assign bad_inc  = bad_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    dwell_d  = dwell_q;
    bad_d    = bad_q;
    mc_d     = 1'b0;
    case (state_q)
      ST_READY: begin
        if (fault) begin
          state_d  = ST_ERROR;
          select_d = SEL_ERROR;
          dwell_d  = 8'd0;
          mc_d     = 1'b1;
        end else if (req_valid) begin
          if (req_mode > 3'd5) begin
            bad_d = bad_inc;
            if (bad_inc == BAD_LIM) begin
              state_d  = ST_ERROR;
              select_d = SEL_ERROR;
              dwell_d  = 8'd0;
              mc_d     = 1'b1;
            end
          end else begin
            bad_d = 4'd0;
            // In READY select always holds a valid mode code, so comparing
            // codes is the same as comparing mode indices.
            if (req_code != select_q) begin
              state_d  = ST_DWELL;
              select_d = req_code;
              dwell_d  = DWELL_LOAD;
              mc_d     = 1'b1;
            end
          end
        end
      end
      ST_DWELL: begin
        if (fault) begin
          state_d  = ST_ERROR;
          select_d = SEL_ERROR;
          dwell_d  = 8'd0;
          mc_d     = 1'b1;
        end else if (dwell_q == 8'd0) begin
          state_d = ST_READY;
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
      end
      ST_ERROR: begin
        if (fault_clr && !fault) begin
          state_d  = ST_READY;
          select_d = 5'b00000;
          bad_d    = 4'd0;
          mc_d     = 1'b1;
        end
      end
      default: begin
        state_d  = ST_READY;
        select_d = 5'b00000;
        dwell_d  = 8'd0;
        bad_d    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_READY;
      select_q <= 5'b00000;
      dwell_q  <= 8'd0;
      bad_q    <= 4'd0;
      mc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      dwell_q  <= dwell_d;
      bad_q    <= bad_d;
      mc_q     <= mc_d;
    end
  end

  assign req_ready    = (state_q == ST_READY);
  assign err          = (state_q == ST_ERROR);
  assign select       = select_q;
  assign mode_changed = mc_q;

endmodule

// File: tb/tb_aquarium_mode_seq.sv
// Bench for aquarium_mode_seq: directed scenarios then random traffic, all
// compared each cycle against a cycle-count reference model.
module tb_aquarium_mode_seq;

  localparam int MIN_DWELL = 16;
  localparam int BAD_LIMIT = 3;

  logic       clk = 1'b0;
  logic       rst, req_valid, fault, fault_clr;
  logic [2:0] req_mode;
  logic       req_ready, mode_changed, err;
  logic [4:0] select;

  int checks = 0;
  int errors = 0;

  // reference model: current mode index, error flag, cycles left before the
  // next request can be accepted, consecutive bad requests, last change pulse
  int m_mode, m_hold, m_bad;
  bit m_err, m_mc;

  aquarium_mode_seq #(.MIN_DWELL(MIN_DWELL), .BAD_LIMIT(BAD_LIMIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .fault(fault), .fault_clr(fault_clr),
    .select(select), .mode_changed(mode_changed), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_select();
    if (m_err) return 5'b11111;
    if (m_mode == 0) return 5'b00000;
    return 5'(1 << (m_mode - 1));
  endfunction

  task automatic model_step();
    m_mc = 1'b0;
    if (rst) begin
      m_mode = 0; m_err = 1'b0; m_hold = 0; m_bad = 0;
    end else if (m_err) begin
      if (fault_clr && !fault) begin
        m_err = 1'b0; m_mode = 0; m_bad = 0; m_mc = 1'b1;
      end
    end else if (fault) begin
      m_err = 1'b1; m_hold = 0; m_mc = 1'b1;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (req_valid) begin
      if (int'(req_mode) > 5) begin
        m_bad++;
        if (m_bad == BAD_LIMIT) begin
          m_err = 1'b1; m_mc = 1'b1;
        end
      end else begin
        m_bad = 0;
        if (int'(req_mode) != m_mode) begin
          m_mode = int'(req_mode); m_hold = MIN_DWELL; m_mc = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("select", select, exp_select());
    chk("mode_changed", 5'(mode_changed), 5'(m_mc));
    chk("err", 5'(err), 5'(m_err));
    chk("req_ready", 5'(req_ready), 5'(!m_err && m_hold == 0));
  endtask

  // drive one cycle of inputs, let the edge happen, compare on the falling edge
  task automatic step(input bit r, input bit v, input int m, input bit f, input bit c);
    rst = r; req_valid = v; req_mode = 3'(m); fault = f; fault_clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_mode = 0; m_err = 1'b0; m_hold = 0; m_bad = 0; m_mc = 1'b0;

    // reset state and req_ready right after release
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_select", select, 5'b00000);
    chk("reset_ready", 5'(req_ready), 5'd1);

    // mode change to 3, then hold a request for 5 through the dwell
    step(0, 1, 3, 0, 0);
    chk("mode3_select", select, 5'b00100);
    chk("mode3_pulse", 5'(mode_changed), 5'd1);
    for (int i = 0; i < 16; i++) step(0, 1, 5, 0, 0);
    chk("dwell_still3", select, 5'b00100);
    step(0, 1, 5, 0, 0);
    chk("mode5_at_17", select, 5'b10000);

    // wait out dwell, then same-mode request and invalid burst with reset by valid
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0);
    chk("same_mode_nopulse", 5'(mode_changed), 5'd0);
    step(0, 1, 7, 0, 0);
    step(0, 1, 6, 0, 0);
    step(0, 1, 5, 0, 0);
    step(0, 1, 7, 0, 0);
    step(0, 1, 7, 0, 0);
    chk("bad2_not_err", 5'(err), 5'd0);
    step(0, 1, 7, 0, 0);
    chk("bad3_err", 5'(err), 5'd1);
    chk("bad3_select", select, 5'b11111);

    // clear with fault high has no effect; fault held gives no pulses
    step(0, 0, 0, 1, 1);
    chk("clr_blocked", select, 5'b11111);
    step(0, 0, 0, 1, 0);
    chk("err_no_pulse", 5'(mode_changed), 5'd0);
    step(0, 0, 0, 0, 1);
    chk("clr_select", select, 5'b00000);
    chk("clr_pulse", 5'(mode_changed), 5'd1);

    // fault beats a simultaneous request
    step(0, 1, 4, 1, 0);
    chk("fault_prio", select, 5'b11111);
    step(0, 0, 0, 0, 1);

    // reset in the middle of a dwell
    step(0, 1, 2, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(1, 1, 4, 1, 0);
    chk("mid_dwell_rst_sel", select, 5'b00000);
    chk("mid_dwell_rst_rdy", 5'(req_ready), 5'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)),
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
